spi_regmap_bridge: RTL

- Parametrised SPI-slave register-map bridge; successor to the fixed-width, write-only SPI control front end.
- Oversamples SPI in the clk_i domain and decodes 2-byte-plus frames (R/W + address, then data).
- Adds read-back, burst auto-increment, read-only status registers, self-clearing pulse bits and abort/error detection.
- Drives control registers for the sobel/gcd datapaths and exposes their status to the host.

---
 rtl/spi_regmap_bridge.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_regmap_bridge.sv
// spi_regmap_bridge: oversampled SPI-slave bridge onto a control/status register map
// with read-back, burst auto-increment, self-clearing pulse bits and sticky frame error.
module spi_regmap_bridge #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CTRL = 16,
    parameter int NUM_STAT = 8,
    parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_RESET = '0,
    parameter logic [NUM_CTRL*DATA_WIDTH-1:0] PULSE_MASK = '0
) (
    input  logic                             clk_i,
    input  logic                             nreset_i,
    input  logic                             spi_sck_i,
    input  logic                             spi_sdi_i,
    input  logic                             spi_cs_ni,
    output logic                             spi_sdo_o,
    output logic                             spi_sdo_oe_o,
    output logic [NUM_CTRL*DATA_WIDTH-1:0]   ctrl_o,
    input  logic [NUM_STAT*DATA_WIDTH-1:0]   status_i,
    output logic                             wr_strobe_o,
    output logic [ADDR_WIDTH-1:0]            wr_addr_o,
    output logic                             frame_err_o
);
    localparam int SW = DATA_WIDTH > 8 ? DATA_WIDTH : 8;
    localparam int CW = $clog2(SW);
    localparam logic [ADDR_WIDTH:0] CTRL_END = (ADDR_WIDTH+1)'(NUM_CTRL);
    localparam logic [ADDR_WIDTH:0] STAT_END = (ADDR_WIDTH+1)'(NUM_CTRL + NUM_STAT);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t state_q, state_d;
    logic [1:0] sck_s, sdi_s, cs_s, live_q;
    logic sck_d, armed_q, rw_q, sdo_q, strobe_q, err_q;
    logic [CW-1:0] cnt_q;
    logic [SW-2:0] sh_q;
    logic [ADDR_WIDTH-1:0] addr_q, wr_addr_q, fa;
    logic [DATA_WIDTH-1:0] tx_q, rdata, wdata;
    logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [7:0] hdr_byte;
    logic sdi, cs_hi, rise, fall, hdr_done, dat_done, fetch, commit, w_ctrl, wr_ctrl;
    logic fa_ok, abort, err_set, err_clr;

    assign sdi = sdi_s[1];
    assign cs_hi = cs_s[1];
    assign rise = sck_s[1] & ~sck_d;
    assign fall = ~sck_s[1] & sck_d;
    assign hdr_byte = {sh_q[6:0], sdi};
    assign wdata = {sh_q[DATA_WIDTH-2:0], sdi};
    assign hdr_done = state_q == S_HDR && !cs_hi && rise && cnt_q == CW'(7);
    assign dat_done = state_q == S_DATA && !cs_hi && rise && cnt_q == CW'(DATA_WIDTH-1);
    assign fa = hdr_done ? hdr_byte[ADDR_WIDTH-1:0] : addr_q + 1'b1;
    assign fa_ok = {1'b0, fa} < STAT_END;
    assign fetch = (hdr_done && !hdr_byte[ADDR_WIDTH]) || (dat_done && !rw_q);
    assign commit = dat_done && rw_q;
    assign w_ctrl = {1'b0, addr_q} < CTRL_END;
    assign wr_ctrl = commit && w_ctrl;
    assign abort = cs_hi && state_q != S_IDLE && cnt_q != '0;
    assign err_clr = commit && (&addr_q);
    assign err_set = abort || (fetch && !fa_ok) || (commit && !w_ctrl && !(&addr_q));

    assign spi_sdo_o = sdo_q;
    assign spi_sdo_oe_o = ~cs_s[1];
    assign ctrl_o = ctrl_q;
    assign wr_strobe_o = strobe_q;
    assign wr_addr_o = wr_addr_q;
    assign frame_err_o = err_q;

    // armed_q blocks a frame until CS has been seen high after reset
    always_comb begin
        state_d = cs_hi ? S_IDLE : (state_q == S_IDLE && armed_q) ? S_HDR : hdr_done ? S_DATA : state_q;
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_CTRL; k++)
            if ({1'b0, fa} == (ADDR_WIDTH+1)'(k)) rdata = ctrl_q[k*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 0; k < NUM_STAT; k++)
            if ({1'b0, fa} == (ADDR_WIDTH+1)'(NUM_CTRL + k)) rdata = status_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // pulse bits drop every cycle; a write landing in the same cycle overrides
    always_comb begin
        ctrl_d = ctrl_q & ~PULSE_MASK;
        for (int k = 0; k < NUM_CTRL; k++)
            if (wr_ctrl && addr_q == ADDR_WIDTH'(k)) ctrl_d[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sck_s <= '0;
            sdi_s <= '1;
            cs_s <= '1;
            sck_d <= 1'b0;
            live_q <= '0;
            armed_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q <= '0;
            sh_q <= '0;
            rw_q <= 1'b0;
            addr_q <= '0;
            tx_q <= '0;
            sdo_q <= 1'b0;
            strobe_q <= 1'b0;
            wr_addr_q <= '0;
            err_q <= 1'b0;
            ctrl_q <= CTRL_RESET;
        end else begin
            sck_s <= {sck_s[0], spi_sck_i};
            sdi_s <= {sdi_s[0], spi_sdi_i};
            cs_s <= {cs_s[0], spi_cs_ni};
            sck_d <= sck_s[1];
            live_q <= {live_q[0], 1'b1};
            armed_q <= armed_q | (live_q[1] & cs_hi);
            state_q <= state_d;
            cnt_q <= (state_q == S_IDLE || cs_hi) ? '0 : !rise ? cnt_q : (hdr_done || dat_done) ? '0 : cnt_q + 1'b1;
            if (rise) sh_q <= {sh_q[SW-3:0], sdi};
            if (hdr_done) begin
                rw_q <= hdr_byte[ADDR_WIDTH];
                addr_q <= hdr_byte[ADDR_WIDTH-1:0];
            end else if (dat_done) begin
                addr_q <= addr_q + 1'b1;
            end
            if (fetch) tx_q <= rdata;
            else if (fall && state_q == S_DATA) tx_q <= tx_q << 1;
            sdo_q <= (state_q != S_DATA || rw_q || cs_hi) ? 1'b0 : fall ? tx_q[DATA_WIDTH-1] : sdo_q;
            strobe_q <= wr_ctrl;
            if (wr_ctrl) wr_addr_q <= addr_q;
            err_q <= err_set | (err_q & ~err_clr);
            ctrl_q <= ctrl_d;
        end
    end
endmodule
